dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer for the word-organised data memory. It accepts load/store requests from the core LSU (port 0) and a DMA/debug master (port 1), and grants them round-robin. It turns byte and halfword stores into read-modify-write sequences and performs byte-lane extraction and sign/zero extension on loads. It sits between both requesters and the data memory, which has a combinational read and a write on the clock edge.

## Interface
- `DEPTH`, default 60: number of 32-bit words in the data memory.
- `IDX_W`, default 6: width of the memory word index; 2^IDX_W must be at least DEPTH.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `reqN_valid` in 1: request from port N (N = 0, 1).
- `reqN_ready` out 1: request accepted this cycle.
- `reqN_we` in 1: 1 = store, 0 = load.
- `reqN_addr` in 32: byte address.
- `reqN_wdata` in 32: store data; the sub-word lives in the low bits.
- `reqN_func3` in 3: RV32 width code.
- `rspN_valid` out 1: one-cycle response pulse.
- `rspN_rdata` out 32: load result; 0 for stores and for errors.
- `rspN_err` out 1: access rejected.
- `mem_addr` out IDX_W: word index.
- `mem_read` out 1: read enable.
- `mem_we` out 1: write enable.
- `mem_wdata` out 32: full-word write data.
- `mem_rdata` in 32: combinational read data.

## Operation
- FSM states: IDLE, ACCESS, MERGE, RESP. Reset state is IDLE.
- Round-robin pointer `prio`: reset value 0. It is set to 1−p after a grant to port p completes its RESP cycle.
- IDLE:
  - If exactly one port is valid, that port is granted.
  - If both are valid, port `prio` is granted.
  - The granted port sees `reqN_ready` = 1 in the same cycle (combinational, IDLE only).
  - we, addr, wdata and func3 are latched, and the FSM moves to ACCESS.
  - If no port is valid, the FSM stays in IDLE.
- Request legality is decoded at latch time:
  - Loads: func3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Stores: func3 ∈ {000 SB, 001 SH, 010 SW}.
  - Halfword accesses require addr[0] = 0; word accesses require addr[1:0] = 0.
  - The word index is addr[IDX_W+1:2] and must be < DEPTH; otherwise the request is illegal.
  - An illegal request goes to RESP directly. No memory access occurs, `mem_we` stays 0, and the response has err = 1 and rdata = 0.
- ACCESS (legal requests):
  - `mem_addr` = word index and `mem_read` = 1.
  - Load: the byte at lane addr[1:0] (or the halfword at lane addr[1]) is selected and extended (sign for LB/LH, zero for LBU/LHU). LW passes the full word. The result is registered and the FSM goes to RESP.
  - SW: `mem_we` = 1 and `mem_wdata` = wdata, then the FSM goes to RESP.
  - SB/SH: `mem_rdata` is captured as the old word and the FSM goes to MERGE.
- MERGE: `mem_we` = 1 and `mem_wdata` = old word with only the addressed byte or halfword replaced by wdata[7:0] or wdata[15:0]. The FSM then goes to RESP.
- RESP: `rspN_valid` = 1 for the granted port only, for exactly one cycle, carrying rdata and err. There is no backpressure. The pointer updates and the FSM returns to IDLE.
- In every non-IDLE state both `reqN_ready` = 0.
- `mem_read` = 0 and `mem_we` = 0 outside ACCESS and MERGE.
- Requesters must hold valid and all fields stable until ready. A request may be dropped freely before it is accepted.

## Timing
- Reset values: all `reqN_ready` = 0, `rspN_valid` = 0, `rspN_rdata` = 0, `rspN_err` = 0, `mem_we` = 0, `mem_read` = 0, `mem_addr` = 0, `mem_wdata` = 0, state IDLE, `prio` = 0.
- Reset asserted mid-operation:
  - The FSM returns to IDLE and any pending write is abandoned.
  - `mem_we` drops immediately, with no clock edge required.
  - No response is produced for the in-flight request.
- Latency, with acceptance (valid & ready) at cycle T:
  - Load: response at T+2.
  - SW: memory written at the end of T+1, response at T+2.
  - SB/SH: memory written at the end of T+2, response at T+3.
  - Illegal request: response at T+1.
- Earliest next acceptance is the cycle after RESP.
  - A single continuous requester is served every 3 cycles (loads/SW) or every 4 cycles (SB/SH).
- Starvation bound: if both ports stay valid, grants strictly alternate.

## Test plan
- Reset, then both ports valid with loads in the same cycle:
  - Port 0 is granted first and `rsp0_valid` is seen at T+2.
  - Port 1 is accepted at T+3 and its response is seen at T+5.
- Memory word 5 = 0x8899AABB, then port 0 issues LB, LBU, LH and LHU at addr 0x15 and 0x16. Required responses:
  - LB → 0xFFFFFFAA.
  - LBU → 0x000000AA.
  - LH at 0x16 → 0xFFFF8899.
  - LHU at 0x16 → 0x00008899.
- Word 3 = 0x11223344, then SB wdata = 0xEF at addr 0x0E:
  - `mem_we` is high only at T+2, with `mem_wdata` = 0x11EF3344.
  - `rsp0_valid` at T+3 with err = 0.
- Misaligned and out-of-range requests:
  - LW at 0x102 → err = 1 and rdata = 0 at T+1.
  - SW to word index 60 → err = 1 at T+1.
  - `mem_we` stays 0 throughout both.
- Port 1 holds valid continuously while port 0 issues 4 back-to-back loads:
  - The grant order is 0,1,0,1,… and no port waits for more than one foreign transaction.
- Assert `rst` during MERGE of an SH:
  - `mem_we` deasserts asynchronously, the memory word is unchanged, and no `rspN_valid` is produced.
  - After release, the first grant goes to port 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for the
// word-organised data memory. Port 0 is the core LSU, port 1 a DMA/debug
// master. Loads are lane-extracted and sign/zero extended. Byte and halfword
// stores become read-modify-write sequences. The memory has a combinational
// read and writes on the rising clock edge.
module dmem_arbiter #(
  parameter int DEPTH = 60,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_we,
  input  logic [31:0]      req0_addr,
  input  logic [31:0]      req0_wdata,
  input  logic [2:0]       req0_func3,
  output logic             rsp0_valid,
  output logic [31:0]      rsp0_rdata,
  output logic             rsp0_err,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_we,
  input  logic [31:0]      req1_addr,
  input  logic [31:0]      req1_wdata,
  input  logic [2:0]       req1_func3,
  output logic             rsp1_valid,
  output logic [31:0]      rsp1_rdata,
  output logic             rsp1_err,

  output logic [IDX_W-1:0] mem_addr,
  output logic             mem_read,
  output logic             mem_we,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_MERGE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  // Control state
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             prio;
  logic             gnt_p0;

  // Arbitration and the selected request
  logic             any_valid;
  logic             sel;
  logic             sel_we;
  logic [IDX_W+1:0] sel_addr;
  logic [31:0]      sel_wdata;
  logic [2:0]       sel_func3;
  logic             sel_legal;
  logic             accept;

  // Latched request (p0) and data captured during ACCESS (p1)
  logic             we_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [1:0]       off_p0;
  logic [31:0]      wdata_p0;
  logic [2:0]       func3_p0;
  logic             err_p0;
  logic [31:0]      rdata_p1;
  logic [31:0]      old_p1;

  // Address bits above the word index do not select memory
  logic             unused_addr_bits;
  assign unused_addr_bits = ^{req0_addr[31:IDX_W+2], req1_addr[31:IDX_W+2]};

  // Format, alignment and range check of a request
  function automatic logic is_legal(input logic we, input logic [IDX_W+1:0] a,
                                    input logic [2:0] f3);
    logic fmt_ok;
    logic align_ok;
    logic range_ok;
    if (we)
      fmt_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else
      fmt_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
               (f3 == 3'b100) || (f3 == 3'b101);
    case (f3[1:0])
      2'b01:   align_ok = ~a[0];
      2'b10:   align_ok = (a[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    range_ok = 32'(a[IDX_W+1:2]) < 32'(DEPTH);
    return fmt_ok && align_ok && range_ok;
  endfunction

  // Select the addressed lane of a loaded word and extend it to 32 bits
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0] off,
                                               input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte or halfword of the old word
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [15:0] wd,
                                              input logic [1:0] off,
                                              input logic half);
    logic [31:0] m;
    m = old;
    if (half) begin
      if (off[1]) m[31:16] = wd;
      else        m[15:0]  = wd;
    end else begin
      case (off)
        2'd0:    m[7:0]   = wd[7:0];
        2'd1:    m[15:8]  = wd[7:0];
        2'd2:    m[23:16] = wd[7:0];
        default: m[31:24] = wd[7:0];
      endcase
    end
    return m;
  endfunction

  // Round-robin pick and mux of the winning request's fields
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) sel = prio;
    else                          sel = req1_valid;
    if (sel) begin
      sel_we    = req1_we;
      sel_addr  = req1_addr[IDX_W+1:0];
      sel_wdata = req1_wdata;
      sel_func3 = req1_func3;
    end else begin
      sel_we    = req0_we;
      sel_addr  = req0_addr[IDX_W+1:0];
      sel_wdata = req0_wdata;
      sel_func3 = req0_func3;
    end
    sel_legal = is_legal(sel_we, sel_addr, sel_func3);
    accept    = (state == S_IDLE) && any_valid;
  end

  assign req0_ready = accept && !sel;
  assign req1_ready = accept && sel;

  // Next-state decode of the access sequencer
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_valid) state_nxt = sel_legal ? S_ACCESS : S_RESP;
      S_ACCESS: state_nxt = (we_p0 && func3_p0[1:0] != 2'b10) ? S_MERGE : S_RESP;
      S_MERGE:  state_nxt = S_RESP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control registers: FSM state, grant owner and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      prio   <= 1'b0;
      gnt_p0 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)            gnt_p0 <= sel;
      if (state == S_RESP)   prio   <= ~gnt_p0;
    end
  end

  // Stage p0 -> p1: latch the accepted request, then capture memory data
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= sel_we;
      idx_p0   <= sel_addr[IDX_W+1:2];
      off_p0   <= sel_addr[1:0];
      wdata_p0 <= sel_wdata;
      func3_p0 <= sel_func3;
      err_p0   <= ~sel_legal;
      rdata_p1 <= '0;
    end
    if (state == S_ACCESS) begin
      if (!we_p0) rdata_p1 <= load_extract(mem_rdata, off_p0, func3_p0);
      old_p1 <= mem_rdata;
    end
  end

  // Memory-side drive; quiet outside ACCESS and MERGE so reset silences it at once
  always_comb begin
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state)
      S_ACCESS: begin
        mem_addr = idx_p0;
        mem_read = 1'b1;
        if (we_p0 && func3_p0[1:0] == 2'b10) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_p0;
        end
      end
      S_MERGE: begin
        mem_addr  = idx_p0;
        mem_we    = 1'b1;
        mem_wdata = store_merge(old_p1, wdata_p0[15:0], off_p0, func3_p0[0]);
      end
      default: ;
    endcase
  end

  // Response pulse to the granted port during RESP only
  always_comb begin
    rsp0_valid = (state == S_RESP) && !gnt_p0;
    rsp1_valid = (state == S_RESP) && gnt_p0;
    rsp0_rdata = rsp0_valid ? rdata_p1 : '0;
    rsp1_rdata = rsp1_valid ? rdata_p1 : '0;
    rsp0_err   = rsp0_valid && err_p0;
    rsp1_err   = rsp1_valid && err_p0;
  end

endmodule
